matmul_seq: RTL and testbench
=============================

Name: matmul_seq

Overview:
- Job sequencer wrapped around the matmul engine and its three BRAMs (A, B, C).
- Accepts N*N words of A, then N*N words of B, on a valid/ready input stream and writes them into the A/B BRAMs.
- Re-arms the engine with a reset pulse, fires start and waits for done.
- Streams the N*N words of C out on a valid/ready output stream in address order, then returns for the next job.

Parameters:
- N, 8, matrix dimension.
- LOG2_N, 3, log2(N).
- DATA_WIDTH, 32, word width of all data paths.
- ADDR_WIDTH, 6, BRAM address width; must equal 2*LOG2_N.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  DATA_WIDTH  load stream word; A row-major, then B row-major.
- in_valid  in  1  load word valid.
- in_ready  out  1  load word accepted when in_valid && in_ready.
- out_data  out  DATA_WIDTH  C word, row-major order.
- out_valid  out  1  C word valid.
- out_ready  in  1  downstream accept.
- a_din  out  DATA_WIDTH  A BRAM write data.
- a_wr_addr  out  ADDR_WIDTH  A BRAM write address.
- a_wr_en  out  1  A BRAM write enable.
- b_din  out  DATA_WIDTH  B BRAM write data.
- b_wr_addr  out  ADDR_WIDTH  B BRAM write address.
- b_wr_en  out  1  B BRAM write enable.
- c_dout  in  DATA_WIDTH  C BRAM read data; 1-cycle registered read.
- c_rd_addr  out  ADDR_WIDTH  C BRAM read address.
- mm_reset  out  1  engine reset, active-high.
- mm_start  out  1  engine start pulse.
- mm_done  in  1  engine done (sticky until engine reset).
- busy  out  1  high in every state except LOAD_A with load count 0.

Behaviour:
- Interface: one clock, clock; reset is asynchronous and active-high, reset.
- Reset values:
  - State LOAD_A; load/unload counters 0; c_rd_addr 0.
  - out_valid 0; out_data 0; mm_start 0.
  - mm_reset 1, holding the engine in reset; deasserts on the first clock edge after reset release.
- States: LOAD_A, LOAD_B, MM_RST, MM_START, MM_WAIT, UNLOAD_RD, UNLOAD_CAP, UNLOAD_OUT.
- Load path (combinational):
  - in_ready = 1 in LOAD_A/LOAD_B only.
  - a_wr_en = in_valid && in_ready && LOAD_A; b_wr_en likewise in LOAD_B.
  - a_din = b_din = in_data; a_wr_addr = b_wr_addr = load counter.
- LOAD_A / LOAD_B: counter increments per accepted word. On the N*N-th accepted word the counter clears and the state advances: LOAD_A->LOAD_B, LOAD_B->MM_RST. Gaps in in_valid stall only.
- MM_RST: mm_reset registered high for exactly one cycle -> MM_START.
- MM_START: mm_start registered high for exactly one cycle, beginning the cycle after mm_reset falls -> MM_WAIT.
- MM_WAIT: hold until mm_done==1 -> UNLOAD_RD with c_rd_addr=0. mm_done is ignored in all other states.
- UNLOAD_RD: address presented for one cycle -> UNLOAD_CAP.
- UNLOAD_CAP: out_data <= c_dout; out_valid <= 1 -> UNLOAD_OUT.
- UNLOAD_OUT: out_data and out_valid are held stable until out_ready. On handshake, out_valid <= 0, then:
  - if c_rd_addr == N*N-1: -> LOAD_A;
  - else c_rd_addr++ -> UNLOAD_RD.
- Throughput: 1 C word per 3 cycles when out_ready is held high.
- Reset mid-operation (any state): immediate return to reset values. The engine is re-reset through mm_reset=1, and no partial output is replayed.
- in_data presented outside the load states is not consumed (in_ready=0).

Optional Feature:
- Macro: MATMUL_SEQ_PERF_EN.
- Defined:
  - Adds output perf_cycles[31:0], a saturating counter of cycles spent in MM_WAIT.
  - Cleared in MM_START; holds its value after MM_WAIT exits until the next MM_START; reset value 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package matmul_seq_pkg holds:
  - state_t enum, 3 bits;
  - localparam NN = N*N;
  - counter width ADDR_WIDTH+1.
- One natural sub-module, matmul_seq_unload: the UNLOAD_RD/CAP/OUT read-capture-handshake path, driven by an enable from the main FSM and returning a last-word flag.

Test Plan:
- N=8, A=identity, B[k]=k+1 streamed with in_valid always high -> out_data sequence 1..64; exactly one mm_reset pulse, then one mm_start pulse on the next cycle.
- in_valid toggled 1-0-1 every other cycle during loads -> exactly 128 BRAM writes at addresses 0..63 each; same C output as above.
- out_ready random 30% duty -> out_data/out_valid stable while stalled; 64 words in order, none lost or duplicated.
- Two back-to-back jobs, A=all 2s and B=all 3s, then A=all 1s and B=all 1s -> first job C=48 everywhere, second job C=8 everywhere; mm_reset pulses before each mm_start.
- reset asserted for 3 cycles during MM_WAIT -> mm_reset=1 and out_valid=0 while reset is held, state returns to LOAD_A; a full job afterwards produces correct C.
- MATMUL_SEQ_PERF_EN defined -> perf_cycles equals the bench-measured cycle count from mm_start falling to mm_done rising; counter held until the next job.

Source files
------------

// File: rtl/matmul_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : matmul_seq_pkg
//  Brief    : Shared types and default constants for the matmul job sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package matmul_seq_pkg;

    localparam int c_N          = 8;
    localparam int c_LOG2_N     = 3;
    localparam int c_ADDR_WIDTH = 2 * c_LOG2_N;
    localparam int c_NN         = c_N * c_N;
    localparam int c_CNT_WIDTH  = c_ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        S_LOAD_A     = 3'd0,
        S_LOAD_B     = 3'd1,
        S_MM_RST     = 3'd2,
        S_MM_START   = 3'd3,
        S_MM_WAIT    = 3'd4,
        S_UNLOAD_RD  = 3'd5,
        S_UNLOAD_CAP = 3'd6,
        S_UNLOAD_OUT = 3'd7
    } state_t;

    // Load counter carries one extra bit so N*N itself is representable.
    function automatic int cnt_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matmul_seq_unload.sv
`default_nettype none
// ============================================================================
//  Module   : matmul_seq_unload
//  Brief    : C BRAM read / capture / output-handshake path of the sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module matmul_seq_unload
    import matmul_seq_pkg::*;
#(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_clear,
    input  logic                  i_cap_en,
    input  logic                  i_out_en,
    input  logic                  i_out_ready,
    input  logic [DATA_WIDTH-1:0] i_c_dout,
    output logic [ADDR_WIDTH-1:0] o_c_rd_addr,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic                  o_out_valid,
    output logic                  o_last,
    output logic                  o_handshake
);

    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(N * N - 1);

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  w_last;
    logic                  w_hs;

    assign w_last = (r_addr == c_LAST_ADDR);
    assign w_hs   = i_out_en && i_out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (i_clear) begin
                r_addr <= '0;
            end
            if (i_cap_en) begin
                r_data  <= i_c_dout;
                r_valid <= 1'b1;
            end
            // Address stays parked on the last word until the next job clears it.
            if (w_hs) begin
                r_valid <= 1'b0;
                if (!w_last) begin
                    r_addr <= r_addr + ADDR_WIDTH'(1);
                end
            end
        end
    end

    assign o_c_rd_addr = r_addr;
    assign o_out_data  = r_data;
    assign o_out_valid = r_valid;
    assign o_last      = w_last;
    assign o_handshake = w_hs;

endmodule
`default_nettype wire

// File: rtl/matmul_seq.sv
`default_nettype none
// ============================================================================
//  Module   : matmul_seq
//  Brief    : Job sequencer: loads A/B BRAMs, runs the matmul engine, streams C.
//             Optional MATMUL_SEQ_PERF_EN adds perf_cycles (MM_WAIT cycle count).
//  Revision : 1.0  initial release
// ============================================================================
module matmul_seq
    import matmul_seq_pkg::*;
#(
    parameter int N          = 8,
    parameter int LOG2_N     = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] a_din,
    output logic [ADDR_WIDTH-1:0] a_wr_addr,
    output logic                  a_wr_en,
    output logic [DATA_WIDTH-1:0] b_din,
    output logic [ADDR_WIDTH-1:0] b_wr_addr,
    output logic                  b_wr_en,
    input  logic [DATA_WIDTH-1:0] c_dout,
    output logic [ADDR_WIDTH-1:0] c_rd_addr,
    output logic                  mm_reset,
    output logic                  mm_start,
    input  logic                  mm_done,
    output logic                  busy
`ifdef MATMUL_SEQ_PERF_EN
    ,
    output logic [31:0]           perf_cycles
`endif
);

    localparam int                c_NN_J      = N * N;
    localparam int                c_CW        = cnt_width(ADDR_WIDTH);
    localparam logic [c_CW-1:0]   c_LOAD_LAST = c_CW'(c_NN_J - 1);

    state_t            r_state;
    logic [c_CW-1:0]   r_load_cnt;
    logic              r_mm_reset;
    logic              r_mm_start;

    logic              w_load;
    logic              w_accept;
    logic              w_load_last;
    logic              w_unload_clear;
    logic              w_unload_cap;
    logic              w_unload_out;
    logic              w_unload_last;
    logic              w_unload_hs;

    assign w_load      = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
    assign w_accept    = in_valid && w_load;
    assign w_load_last = (r_load_cnt == c_LOAD_LAST);

    assign in_ready  = w_load;
    assign a_wr_en   = w_accept && (r_state == S_LOAD_A);
    assign b_wr_en   = w_accept && (r_state == S_LOAD_B);
    assign a_din     = in_data;
    assign b_din     = in_data;
    assign a_wr_addr = r_load_cnt[2*LOG2_N-1:0];
    assign b_wr_addr = r_load_cnt[2*LOG2_N-1:0];

    assign busy     = !((r_state == S_LOAD_A) && (r_load_cnt == '0));
    assign mm_reset = r_mm_reset;
    assign mm_start = r_mm_start;

    assign w_unload_clear = (r_state == S_MM_WAIT) && mm_done;
    assign w_unload_cap   = (r_state == S_UNLOAD_CAP);
    assign w_unload_out   = (r_state == S_UNLOAD_OUT);

    matmul_seq_unload #(
        .N          (N),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_unload (
        .clock       (clock),
        .reset       (reset),
        .i_clear     (w_unload_clear),
        .i_cap_en    (w_unload_cap),
        .i_out_en    (w_unload_out),
        .i_out_ready (out_ready),
        .i_c_dout    (c_dout),
        .o_c_rd_addr (c_rd_addr),
        .o_out_data  (out_data),
        .o_out_valid (out_valid),
        .o_last      (w_unload_last),
        .o_handshake (w_unload_hs)
    );

    // mm_reset powers up high so the engine is held in reset until the first edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_LOAD_A;
            r_load_cnt <= '0;
            r_mm_reset <= 1'b1;
            r_mm_start <= 1'b0;
        end else begin
            r_mm_reset <= 1'b0;
            r_mm_start <= 1'b0;
            case (r_state)
                S_LOAD_A: begin
                    if (w_accept) begin
                        if (w_load_last) begin
                            r_load_cnt <= '0;
                            r_state    <= S_LOAD_B;
                        end else begin
                            r_load_cnt <= r_load_cnt + c_CW'(1);
                        end
                    end
                end
                S_LOAD_B: begin
                    if (w_accept) begin
                        if (w_load_last) begin
                            r_load_cnt <= '0;
                            r_mm_reset <= 1'b1;
                            r_state    <= S_MM_RST;
                        end else begin
                            r_load_cnt <= r_load_cnt + c_CW'(1);
                        end
                    end
                end
                S_MM_RST: begin
                    r_mm_start <= 1'b1;
                    r_state    <= S_MM_START;
                end
                S_MM_START: begin
                    r_state <= S_MM_WAIT;
                end
                S_MM_WAIT: begin
                    if (mm_done) begin
                        r_state <= S_UNLOAD_RD;
                    end
                end
                S_UNLOAD_RD: begin
                    r_state <= S_UNLOAD_CAP;
                end
                S_UNLOAD_CAP: begin
                    r_state <= S_UNLOAD_OUT;
                end
                S_UNLOAD_OUT: begin
                    if (w_unload_hs) begin
                        r_state <= w_unload_last ? S_LOAD_A : S_UNLOAD_RD;
                    end
                end
                default: begin
                    r_state <= S_LOAD_A;
                end
            endcase
        end
    end

`ifdef MATMUL_SEQ_PERF_EN
    logic [31:0] r_perf;

    // Counts MM_WAIT cycles spent before done is seen; saturates at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_perf <= '0;
        end else if (r_state == S_MM_START) begin
            r_perf <= '0;
        end else if ((r_state == S_MM_WAIT) && !mm_done && (r_perf != '1)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cycles = r_perf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_matmul_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matmul_seq
//  Brief    : Self-checking bench for matmul_seq with behavioural BRAMs/engine.
//  Revision : 1.0  initial release
// ============================================================================
module tb_matmul_seq;

    localparam int N  = 8;
    localparam int NN = N * N;
    localparam int DW = 32;
    localparam int AW = 6;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] a_din, b_din;
    logic [AW-1:0] a_wr_addr, b_wr_addr, c_rd_addr;
    logic          a_wr_en, b_wr_en;
    logic [DW-1:0] c_dout = '0;
    logic          mm_reset, mm_start, busy;
    logic          mm_done = 1'b0;
`ifdef MATMUL_SEQ_PERF_EN
    logic [31:0]   perf_cycles;
`endif

    always #5 clock = ~clock;

    matmul_seq #(.N(N), .LOG2_N(3), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .a_din(a_din), .a_wr_addr(a_wr_addr), .a_wr_en(a_wr_en),
        .b_din(b_din), .b_wr_addr(b_wr_addr), .b_wr_en(b_wr_en),
        .c_dout(c_dout), .c_rd_addr(c_rd_addr),
        .mm_reset(mm_reset), .mm_start(mm_start), .mm_done(mm_done),
        .busy(busy)
`ifdef MATMUL_SEQ_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Behavioural environment: BRAMs with 1-cycle read and a fixed-latency engine.
    logic [DW-1:0] a_mem [NN];
    logic [DW-1:0] b_mem [NN];
    logic [DW-1:0] c_mem [NN];
    int            eng_lat = 10;
    int            eng_cnt = 0;
    logic          eng_run = 1'b0;

    always @(posedge clock) begin : eng
        logic [DW-1:0] acc;
        if (a_wr_en) a_mem[a_wr_addr] <= a_din;
        if (b_wr_en) b_mem[b_wr_addr] <= b_din;
        c_dout <= c_mem[c_rd_addr];
        if (mm_reset) begin
            mm_done <= 1'b0;
            eng_run <= 1'b0;
        end else if (mm_start) begin
            eng_run <= 1'b1;
            eng_cnt <= eng_lat;
        end else if (eng_run) begin
            if (eng_cnt == 0) begin
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        acc = '0;
                        for (int k = 0; k < N; k++) acc = acc + a_mem[i*N+k] * b_mem[k*N+j];
                        c_mem[i*N+j] <= acc;
                    end
                end
                mm_done <= 1'b1;
                eng_run <= 1'b0;
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    // Reference model: matrices as sent, expected C in row-major order.
    logic [DW-1:0] ma [NN];
    logic [DW-1:0] mb [NN];
    logic [DW-1:0] exp_q [$];

    task automatic build_expected();
        logic [DW-1:0] s;
        exp_q.delete();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                s = '0;
                for (int k = 0; k < N; k++) s += ma[r*N+k] * mb[k*N+c];
                exp_q.push_back(s);
            end
        end
    endtask

    int ready_pct = 100;
    always @(posedge clock) begin
        #1;
        out_ready = ($urandom_range(99) < ready_pct);
    end

    // Monitor sampled on the falling edge.
    int            wr_a = 0, wr_b = 0, n_rst_hi = 0, n_start = 0, n_out = 0, n_extra = 0;
    logic          prev_ov = 1'b0, prev_or = 1'b0, prev_mmr = 1'b0, prev_st = 1'b0;
    logic [DW-1:0] prev_od = '0;
    int            meas = 0;
    logic          measuring = 1'b0;

    always @(negedge clock) begin
        if (!reset) begin
            if (a_wr_en) begin
                check_eq("a_wr_addr", a_wr_addr, wr_a % NN);
                check_eq("a_din", a_din, ma[wr_a % NN]);
                wr_a++;
            end
            if (b_wr_en) begin
                check_eq("b_wr_addr", b_wr_addr, wr_b % NN);
                check_eq("b_din", b_din, mb[wr_b % NN]);
                wr_b++;
            end
            if (mm_reset) n_rst_hi++;
            if (mm_start) begin
                n_start++;
                check_eq("start_after_rst", prev_mmr, 1);
                check_eq("in_ready_busy", in_ready, 0);
            end
            if (prev_ov && !prev_or) begin
                check_eq("stall_valid", out_valid, 1);
                check_eq("stall_data", out_data, prev_od);
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) n_extra++;
                else check_eq("out_data", out_data, exp_q.pop_front());
            end
            if (measuring) begin
                if (!mm_done) meas++;
                else measuring = 1'b0;
            end
            if (prev_st && !mm_start) begin
                measuring = !mm_done;
                meas = mm_done ? 0 : 1;
            end
            prev_ov = out_valid;
            prev_or = out_ready;
            prev_od = out_data;
        end else begin
            prev_ov = 1'b0;
            prev_or = 1'b0;
            measuring = 1'b0;
        end
        prev_mmr = mm_reset;
        prev_st  = mm_start;
    end

    task automatic load_words(input bit gap);
        int guard;
        for (int k = 0; k < 2*NN; k++) begin
            if (gap) begin
                in_valid = 1'b0;
                @(posedge clock); #1;
            end
            in_valid = 1'b1;
            in_data  = (k < NN) ? ma[k] : mb[k-NN];
            guard = 0;
            while (!in_ready && guard < 100) begin
                @(posedge clock); #1;
                guard++;
            end
            check_eq("load_timeout", guard >= 100, 0);
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_job(input bit gap, input int pct);
        int guard;
        ready_pct = pct;
        eng_lat   = $urandom_range(3, 40);
        build_expected();
        wr_a = 0; wr_b = 0; n_rst_hi = 0; n_start = 0; n_out = 0; n_extra = 0;
        @(negedge clock);
        check_eq("busy_idle", busy, 0);
        @(posedge clock); #1;
        load_words(gap);
        guard = 0;
        // Garbage on the input while busy must not be consumed.
        while ((exp_q.size() != 0 || busy) && guard < 20000) begin
            in_valid = busy;
            in_data  = $urandom;
            @(posedge clock); #1;
            guard++;
        end
        in_valid = 1'b0;
        check_eq("job_timeout", guard >= 20000, 0);
        check_eq("a_writes", wr_a, NN);
        check_eq("b_writes", wr_b, NN);
        check_eq("out_words", n_out, NN);
        check_eq("extra_words", n_extra, 0);
        check_eq("mm_reset_cycles", n_rst_hi, 1);
        check_eq("mm_start_pulses", n_start, 1);
`ifdef MATMUL_SEQ_PERF_EN
        check_eq("perf_cycles", perf_cycles, meas);
        repeat (5) @(posedge clock);
        #1;
        check_eq("perf_hold", perf_cycles, meas);
`endif
        ready_pct = 100;
    endtask

    initial begin
        int guard;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_mm_reset", mm_reset, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_mm_start", mm_start, 0);
        check_eq("rst_c_rd_addr", c_rd_addr, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_in_ready", in_ready, 1);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check_eq("mm_reset_held", mm_reset, 1);
        @(negedge clock);
        check_eq("mm_reset_release", mm_reset, 0);

        // Identity x (k+1) gives 1..64; streamed continuously, then with gaps.
        for (int k = 0; k < NN; k++) begin
            ma[k] = ((k / N) == (k % N)) ? 32'd1 : 32'd0;
            mb[k] = 32'(k + 1);
        end
        run_job(1'b0, 100);
        run_job(1'b1, 100);

        for (int k = 0; k < NN; k++) begin
            ma[k] = $urandom;
            mb[k] = $urandom;
        end
        run_job(1'b0, 30);

        for (int k = 0; k < NN; k++) begin ma[k] = 32'd2; mb[k] = 32'd3; end
        run_job(1'b0, 100);
        for (int k = 0; k < NN; k++) begin ma[k] = 32'd1; mb[k] = 32'd1; end
        run_job(1'b0, 100);

        // Reset during MM_WAIT: no output may appear afterwards from that job.
        for (int k = 0; k < NN; k++) begin
            ma[k] = $urandom_range(255);
            mb[k] = $urandom_range(255);
        end
        exp_q.delete();
        wr_a = 0; wr_b = 0; n_extra = 0;
        eng_lat = 300;
        load_words(1'b0);
        guard = 0;
        while (!mm_start && guard < 100) begin
            @(posedge clock); #1;
            guard++;
        end
        check_eq("wait_start_timeout", guard >= 100, 0);
        repeat (5) @(posedge clock);
        #1;
        check_eq("pre_rst_busy", busy, 1);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check_eq("midrst_mm_reset", mm_reset, 1);
            check_eq("midrst_out_valid", out_valid, 0);
            check_eq("midrst_busy", busy, 0);
            check_eq("midrst_in_ready", in_ready, 1);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        check_eq("midrst_extra", n_extra, 0);

        for (int k = 0; k < NN; k++) begin
            ma[k] = $urandom;
            mb[k] = $urandom;
        end
        run_job(1'b0, 60);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
